// File: rtl/nco_pkg.sv
// Shared types and constants for the quarter-wave NCO: quadrant enum,
// quarter-table generator and dither LFSR constants.
package nco_pkg;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_e;

  // Largest supported table index width; the table type is sized for it.
  localparam int QT_MAX_AW = 10;
  localparam int QT_N      = 2**(QT_MAX_AW-2) + 1;
  localparam int QT_IDX_W  = $clog2(QT_N);

  typedef logic [QT_N-1:0][15:0] qtab_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Galois taps 16,14,13,11 for a right-shifting register
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam real NCO_PI = 3.14159265358979323846;

  // Q[k] = round(amp*sin(2*pi*k/2^addr_w)), k = 0..2^(addr_w-2); all entries >= 0
  function automatic qtab_t gen_qtab(input int amp, input int addr_w);
    qtab_t t;
    t = '0;
    for (int k = 0; k <= 2**(addr_w-2); k++)
      t[QT_IDX_W'(k)] = 16'($rtoi(amp * $sin(2.0 * NCO_PI * k / (2.0 ** addr_w)) + 0.5));
    return t;
  endfunction

endpackage

// File: rtl/nco_quarter_rom.sv
// Combinational quarter-wave magnitude lookup, folded address 0..2^(ADDR_W-2).
module nco_quarter_rom import nco_pkg::*; #(
  parameter int AMP    = 100,
  parameter int ADDR_W = 7,
  parameter int DW     = 9
) (
  input  logic [ADDR_W-2:0] addr,
  output logic [DW-2:0]     mag
);

  localparam qtab_t QTAB = gen_qtab(AMP, ADDR_W);

  logic [QT_IDX_W-1:0] idx;

  assign idx = QT_IDX_W'(addr);
  assign mag = (DW-1)'(QTAB[idx]);

endmodule

// File: rtl/nco_quad_lut.sv
// Multi-channel NCO: per-channel phase accumulators feeding a shared-shape
// quarter-wave table. Define NCO_DITHER_EN to add LFSR phase dither.
module nco_quad_lut import nco_pkg::*; #(
  parameter  int CH     = 2,
  parameter  int ACC_W  = 16,
  parameter  int ADDR_W = 7,
  parameter  int DW     = 9,
  parameter  int AMP    = 100,
  localparam int CHW    = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               sync_clr,
  input  logic               cfg_wr,
  input  logic [CHW-1:0]     cfg_ch,
  input  logic [ACC_W-1:0]   cfg_freq,
  input  logic [ADDR_W-1:0]  cfg_ofs,
  output logic [CH*DW-1:0]   sin_out,
  output logic [CH*DW-1:0]   cos_out,
  output logic               out_valid
);

  localparam int STAGES = 2;
  localparam int Q4     = 2**(ADDR_W-2);

  if (AMP > 2**(DW-1)-1) begin : g_amp_err
    $error("nco_quad_lut: AMP does not fit the signed DW-bit output");
  end
  if (ADDR_W < 3 || ADDR_W > QT_MAX_AW || DW > 17) begin : g_geom_err
    $error("nco_quad_lut: unsupported ADDR_W/DW");
  end

  logic [CH-1:0][ACC_W-1:0]  acc, freq, acc_ph;
  logic [CH-1:0][ADDR_W-1:0] ofs, ph;
  logic [CH-1:0][ADDR_W-2:0] s_addr, c_addr;
  logic [CH-1:0]             s_neg, c_neg;
  logic [CH-1:0][DW-2:0]     s_mag, c_mag;
  logic [CH-1:0][DW-1:0]     sin_q, cos_q;
  logic [STAGES:1]           vld_pipe;

  // Folds a full-wave index into {negate, quarter-table address}.
  function automatic logic [ADDR_W-1:0] fold(input logic [ADDR_W-1:0] p);
    quad_e             qd;
    logic [ADDR_W-2:0] r;
    qd = quad_e'(p[ADDR_W-1 -: 2]);
    r  = {1'b0, p[ADDR_W-3:0]};
    if (qd == Q1 || qd == Q3) r = (ADDR_W-1)'(Q4) - r;
    return {(qd == Q2 || qd == Q3), r};
  endfunction

`ifdef NCO_DITHER_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or posedge rst)
    if (rst)     lfsr <= LFSR_SEED;
    else if (en) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0);
`endif

  // Table index from the pre-update accumulator; dither touches only this copy.
  always_comb begin
    acc_ph = acc;
    ph     = '0;
`ifdef NCO_DITHER_EN
    for (int c = 0; c < CH; c++)
      acc_ph[c] = acc[c] + ACC_W'(lfsr[ACC_W-ADDR_W-1:0]);
`endif
    for (int c = 0; c < CH; c++)
      ph[c] = acc_ph[c][ACC_W-1 -: ADDR_W] + ofs[c];
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc  <= '0;
      freq <= '0;
      ofs  <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (sync_clr)  acc[c] <= '0;
        else if (en)   acc[c] <= acc[c] + freq[c];
        if (cfg_wr && cfg_ch == CHW'(c)) begin
          freq[c] <= cfg_freq;
          ofs[c]  <= cfg_ofs;
        end
      end
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vld_pipe <= '0;
      s_addr   <= '0;
      s_neg    <= '0;
      c_addr   <= '0;
      c_neg    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], en};
      if (en)
        for (int c = 0; c < CH; c++) begin
          {s_neg[c], s_addr[c]} <= fold(ph[c]);
          {c_neg[c], c_addr[c]} <= fold(ph[c] + ADDR_W'(Q4));
        end
    end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    nco_quarter_rom #(.AMP(AMP), .ADDR_W(ADDR_W), .DW(DW)) u_sin (
      .addr (s_addr[c]),
      .mag  (s_mag[c])
    );
    nco_quarter_rom #(.AMP(AMP), .ADDR_W(ADDR_W), .DW(DW)) u_cos (
      .addr (c_addr[c]),
      .mag  (c_mag[c])
    );
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sin_q <= '0;
      cos_q <= '0;
    end else if (vld_pipe[1]) begin
      for (int c = 0; c < CH; c++) begin
        sin_q[c] <= s_neg[c] ? DW'(0) - {1'b0, s_mag[c]} : {1'b0, s_mag[c]};
        cos_q[c] <= c_neg[c] ? DW'(0) - {1'b0, c_mag[c]} : {1'b0, c_mag[c]};
      end
    end

  assign sin_out   = sin_q;
  assign cos_out   = cos_q;
  assign out_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_nco_quad_lut.sv
// Directed bench for nco_quad_lut with hand-computed table values
// (AMP=100, ADDR_W=7: Q[1]=5 Q[2]=10 Q[3]=15 Q[5]=24 Q[10]=47 Q[16]=71 Q[22]=88 Q[32]=100).
module tb_nco_quad_lut;

  localparam int CH = 2, ACC_W = 16, ADDR_W = 7, DW = 9, AMP = 100;

  logic              clk = 1'b0;
  logic              rst, en, sync_clr, cfg_wr;
  logic [0:0]        cfg_ch;
  logic [ACC_W-1:0]  cfg_freq;
  logic [ADDR_W-1:0] cfg_ofs;
  logic [CH*DW-1:0]  sin_out, cos_out;
  logic              out_valid;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  nco_quad_lut #(.CH(CH), .ACC_W(ACC_W), .ADDR_W(ADDR_W), .DW(DW), .AMP(AMP)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sync_clr  (sync_clr),
    .cfg_wr    (cfg_wr),
    .cfg_ch    (cfg_ch),
    .cfg_freq  (cfg_freq),
    .cfg_ofs   (cfg_ofs),
    .sin_out   (sin_out),
    .cos_out   (cos_out),
    .out_valid (out_valid)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic int sin_ch(input int c);
    return int'($signed(sin_out[c*DW +: DW]));
  endfunction

  function automatic int cos_ch(input int c);
    return int'($signed(cos_out[c*DW +: DW]));
  endfunction

  task automatic cfg(input int ch, input logic [ACC_W-1:0] f, input logic [ADDR_W-1:0] o);
    cfg_wr = 1'b1; cfg_ch = 1'(ch); cfg_freq = f; cfg_ofs = o;
    step;
    cfg_wr = 1'b0;
  endtask

  task automatic clr_acc;
    sync_clr = 1'b1;
    step;
    sync_clr = 1'b0;
  endtask

  task automatic test_reset;
    n_run++;
    if (sin_out !== '0 || cos_out !== '0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: sin=%h cos=%h vld=%b, want 0 0 0", sin_out, cos_out, out_valid);
    end
    cfg(0, 16'd512, '0);
    en = 1'b1; repeat (4) step; en = 1'b0;
    #3 rst = 1'b1;
    #1;
    n_run++;
    if (sin_out !== '0 || cos_out !== '0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: sin=%h cos=%h vld=%b, want 0 0 0", sin_out, cos_out, out_valid);
    end
    step;
    #2 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step;
      n_run++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stale_valid: cycle %0d vld=%b, want 0", k, out_valid);
      end
    end
    en = 1'b1; step; en = 1'b0;
    step;
    n_run++;
    if (out_valid !== 1'b1 || sin_ch(0) !== 0 || cos_ch(0) !== 100) begin
      n_fail++;
      $display("FAIL first_sample: vld=%b sin=%0d cos=%0d, want 1 0 100", out_valid, sin_ch(0), cos_ch(0));
    end
    step;
    n_run++;
    if (out_valid !== 1'b0 || cos_ch(0) !== 100) begin
      n_fail++;
      $display("FAIL pulse_hold: vld=%b cos=%0d, want 0 100", out_valid, cos_ch(0));
    end
  endtask

  task automatic test_sweep;
    int s [128];
    int c [128];
    cfg(0, 16'd512, '0);
    clr_acc;
    en = 1'b1;
    for (int k = 1; k <= 129; k++) begin
      step;
      if (k >= 2) begin
        s[k-2] = sin_ch(0);
        c[k-2] = cos_ch(0);
        n_run++;
        if (out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL back_to_back_valid: sample %0d vld=%b, want 1", k-2, out_valid);
        end
      end
    end
    en = 1'b0;
    n_run++;
    if (s[32] !== 100 || c[32] !== 0) begin
      n_fail++; $display("FAIL sweep_idx32: sin=%0d cos=%0d, want 100 0", s[32], c[32]);
    end
    n_run++;
    if (s[64] !== 0 || c[64] !== -100) begin
      n_fail++; $display("FAIL sweep_idx64: sin=%0d cos=%0d, want 0 -100", s[64], c[64]);
    end
    n_run++;
    if (s[96] !== -100 || c[96] !== 0) begin
      n_fail++; $display("FAIL sweep_idx96: sin=%0d cos=%0d, want -100 0", s[96], c[96]);
    end
    n_run++;
    if (s[16] !== 71 || c[16] !== 71) begin
      n_fail++; $display("FAIL sweep_idx16: sin=%0d cos=%0d, want 71 71", s[16], c[16]);
    end
    n_run++;
    if (s[1] !== 5 || s[0] !== 0 || c[0] !== 100) begin
      n_fail++; $display("FAIL sweep_idx0_1: sin1=%0d sin0=%0d cos0=%0d, want 5 0 100", s[1], s[0], c[0]);
    end
    for (int k = 1; k < 128; k++) begin
      n_run++;
      if (s[128-k] !== -s[k]) begin
        n_fail++; $display("FAIL sweep_symmetry: k=%0d sin(128-k)=%0d, want %0d", k, s[128-k], -s[k]);
      end
    end
    for (int k = 0; k < 128; k++) begin
      n_run++;
      if (c[k] !== s[(k+32)%128]) begin
        n_fail++; $display("FAIL sweep_cos_shift: k=%0d cos=%0d, want %0d", k, c[k], s[(k+32)%128]);
      end
    end
  endtask

  task automatic test_offset;
    cfg(0, 16'd512, '0);
    cfg(1, 16'd512, 7'd32);
    clr_acc;
    en = 1'b1;
    for (int k = 1; k <= 41; k++) begin
      step;
      if (k >= 2) begin
        n_run++;
        if (sin_ch(1) !== cos_ch(0)) begin
          n_fail++; $display("FAIL offset_match: sample %0d ch1 sin=%0d, want %0d", k-2, sin_ch(1), cos_ch(0));
        end
      end
      if (k == 2) begin
        n_run++;
        if (sin_ch(1) !== 100 || cos_ch(1) !== 0) begin
          n_fail++; $display("FAIL offset_first: ch1 sin=%0d cos=%0d, want 100 0", sin_ch(1), cos_ch(1));
        end
      end
    end
    en = 1'b0;
    clr_acc;
    cfg(1, '0, '0);
  endtask

  task automatic test_config_race;
    int exp_s [4];
    exp_s = '{0, 5, 15, 24};
    en = 1'b1;
    cfg_wr = 1'b1; cfg_ch = 1'b0; cfg_freq = 16'd1024; cfg_ofs = '0;
    for (int k = 1; k <= 5; k++) begin
      step;
      cfg_wr = 1'b0;
      if (k == 4) en = 1'b0;
      if (k >= 2) begin
        n_run++;
        if (sin_ch(0) !== exp_s[k-2] || out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL config_race: sample %0d sin=%0d vld=%b, want %0d 1", k-2, sin_ch(0), out_valid, exp_s[k-2]);
        end
      end
    end
  endtask

  task automatic test_wrap;
    int exp_s [4];
    exp_s = '{0, -5, -10, -15};
    cfg(0, 16'hFE00, '0);
    clr_acc;
    en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step;
      if (k == 4) en = 1'b0;
      if (k >= 2) begin
        n_run++;
        if (sin_ch(0) !== exp_s[k-2] || out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL wrap: sample %0d sin=%0d vld=%b, want %0d 1", k-2, sin_ch(0), out_valid, exp_s[k-2]);
        end
      end
      if (k == 3) begin
        n_run++;
        if (cos_ch(0) !== 100) begin
          n_fail++; $display("FAIL wrap_cos127: cos=%0d, want 100", cos_ch(0));
        end
      end
    end
  endtask

  task automatic test_sync_clr;
    cfg(0, 16'd512, '0);
    clr_acc;
    en = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step;
      if (k == 12) begin
        n_run++;
        if (out_valid !== 1'b1 || sin_ch(0) !== 47 || cos_ch(0) !== 88) begin
          n_fail++;
          $display("FAIL sync_clr_old_phase: vld=%b sin=%0d cos=%0d, want 1 47 88", out_valid, sin_ch(0), cos_ch(0));
        end
      end
      if (k == 13) begin
        n_run++;
        if (out_valid !== 1'b1 || sin_ch(0) !== 0 || cos_ch(0) !== 100) begin
          n_fail++;
          $display("FAIL sync_clr_phase0: vld=%b sin=%0d cos=%0d, want 1 0 100", out_valid, sin_ch(0), cos_ch(0));
        end
      end
      if (k == 14) begin
        n_run++;
        if (out_valid !== 1'b0) begin
          n_fail++; $display("FAIL sync_clr_latency: vld=%b, want 0", out_valid);
        end
      end
      if (k == 10) sync_clr = 1'b1;
      if (k == 11) sync_clr = 1'b0;
      if (k == 12) en = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sync_clr = 1'b0; cfg_wr = 1'b0;
    cfg_ch = '0; cfg_freq = '0; cfg_ofs = '0;
    repeat (2) step;
    rst = 1'b0;
    test_reset;
    test_sweep;
    test_offset;
    test_config_race;
    test_wrap;
    test_sync_clr;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
